// File: rtl/imu_seq_pkg.sv
// imu_seq_pkg: state encoding, configuration write list and read-burst address table for imu_seq.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Build option IMU_ACCEL_EN: extends the read burst with the Y-acceleration registers.
package imu_seq_pkg;

  typedef enum logic [2:0] {
    PWR,
    CFG,
    CFG_WAIT,
    IDLE,
    RD,
    RD_WAIT,
    VLD
  } state_t;

  // Sensor configuration writes, issued once after power-up in this order:
  // INT on data ready, accel ODR, gyro ODR, rounding.
  localparam int NUM_CFG   = 4;
  localparam int CFG_IDX_W = $clog2(NUM_CFG);
  localparam logic [15:0] CFG_LIST [NUM_CFG] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

  // Read burst sizes for the two builds.
  localparam int NUM_RD_YAW   = 2;
  localparam int NUM_RD_ACCEL = 4;

`ifdef IMU_ACCEL_EN
  localparam bit ACCEL_EN = 1'b1;
`else
  localparam bit ACCEL_EN = 1'b0;
`endif

  localparam int NUM_RD   = ACCEL_EN ? NUM_RD_ACCEL : NUM_RD_YAW;
  localparam int RD_IDX_W = $clog2(NUM_RD);

  // Register addresses read per data-ready event: yaw L/H, then accel Y L/H.
`ifdef IMU_ACCEL_EN
  localparam logic [6:0] RD_ADDR [NUM_RD] = '{7'h26, 7'h27, 7'h2A, 7'h2B};
`else
  localparam logic [6:0] RD_ADDR [NUM_RD] = '{7'h26, 7'h27};
`endif

  // SPI read command: rw bit set, 7-bit address, dummy data byte.
  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/imu_seq_if.sv
// imu_seq_if: bundles the SPI monarch handshake and the sensor result bus of imu_seq.
// Latency: n/a (wires only).
// Backpressure: none; done/wrt form a start/complete handshake, vld is a strobe with no ready.
// Signals: INT (sensor data-ready), done/rd_data (from SPI monarch), wrt/cmd (to SPI monarch),
//          yaw_rt/ay/vld (sample output), cfg_done (configuration finished).
interface imu_seq_if;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic [15:0] ay;
  logic        vld;
  logic        cfg_done;

  // master: the sequencer side.
  modport master (
    input  INT, done, rd_data,
    output wrt, cmd, yaw_rt, ay, vld, cfg_done
  );

  // slave: the sensor/SPI/consumer side.
  modport slave (
    output INT, done, rd_data,
    input  wrt, cmd, yaw_rt, ay, vld, cfg_done
  );
endinterface

// File: rtl/imu_int_sync.sv
// imu_int_sync: two-flop synchroniser for the asynchronous sensor interrupt plus rising-edge pulse.
// Latency: pulse is visible 2 clocks after INT is sampled high (one-cycle wide).
// Backpressure: none; the pulse is always produced.
// Ports: clk, rst (async active-high), i_async (raw INT), o_rise (one-cycle edge pulse).
module imu_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Edge detect is taken on the synchronised copy only; r_meta is never used downstream.
  assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/imu_seq.sv
// imu_seq: power-up wait, sensor configuration writes, then INT-triggered register read bursts.
// Latency: INT edge to first wrt 4 clocks; final done of a burst to vld 2 clocks; done to next wrt 2 clocks.
// Backpressure: waits on SPI done for every transaction; at most one INT edge is held pending.
// Ports: clk, rst (async active-high), bus (imu_seq_if.master: INT, done, rd_data in;
//        wrt, cmd, yaw_rt, ay, vld, cfg_done out). Parameter PWR_WAIT: power-up clocks.
// Build option IMU_ACCEL_EN: also reads 0x2A/0x2B and drives ay; otherwise ay is tied to zero.
module imu_seq
  import imu_seq_pkg::*;
#(
  parameter logic [15:0] PWR_WAIT = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  imu_seq_if.master bus
);

  state_t                r_state;
  logic [15:0]           r_pwr_cnt;
  logic [CFG_IDX_W-1:0]  r_idx;
  logic [RD_IDX_W-1:0]   r_ridx;
  logic                  r_pend;
  logic                  r_wrt;
  logic                  r_vld;
  logic                  r_cfg_done;
  logic [15:0]           r_cmd;
  logic [15:0]           r_yaw;
  logic [7:0]            r_byte [NUM_RD];
`ifdef IMU_ACCEL_EN
  logic [15:0]           r_ay;
`endif

  logic                  w_int_rise;
  logic                  w_in_burst;
  logic [7:0]            w_unused_rd_hi;

  // Only the low byte of the SPI read word carries register data.
  assign w_unused_rd_hi = bus.rd_data[15:8];

  imu_int_sync u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.INT),
    .o_rise  (w_int_rise)
  );

  // Edges arriving while a burst is in flight are remembered (one deep);
  // edges before configuration completes are dropped.
  assign w_in_burst = (r_state == RD) || (r_state == RD_WAIT) || (r_state == VLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PWR;
      r_pwr_cnt  <= 16'h0000;
      r_idx      <= '0;
      r_ridx     <= '0;
      r_pend     <= 1'b0;
      r_wrt      <= 1'b0;
      r_vld      <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cmd      <= 16'h0000;
      r_yaw      <= 16'h0000;
      for (int i = 0; i < NUM_RD; i++) begin
        r_byte[i] <= 8'h00;
      end
`ifdef IMU_ACCEL_EN
      r_ay       <= 16'h0000;
`endif
    end else begin
      r_wrt <= 1'b0;
      r_vld <= 1'b0;

      if (w_int_rise && w_in_burst) begin
        r_pend <= 1'b1;
      end

      case (r_state)
        PWR: begin
          if (r_pwr_cnt == PWR_WAIT) begin
            r_state <= CFG;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 16'd1;
          end
        end

        CFG: begin
          r_cmd   <= CFG_LIST[r_idx];
          r_wrt   <= 1'b1;
          r_state <= CFG_WAIT;
        end

        CFG_WAIT: begin
          if (bus.done) begin
            r_idx <= r_idx + CFG_IDX_W'(1);
            if (r_idx == CFG_IDX_W'(NUM_CFG - 1)) begin
              r_cfg_done <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_state <= CFG;
            end
          end
        end

        IDLE: begin
          if (w_int_rise || r_pend) begin
            r_pend  <= 1'b0;
            r_ridx  <= '0;
            r_state <= RD;
          end
        end

        RD: begin
          r_cmd   <= rd_cmd(RD_ADDR[r_ridx]);
          r_wrt   <= 1'b1;
          r_state <= RD_WAIT;
        end

        RD_WAIT: begin
          if (bus.done) begin
            r_byte[r_ridx] <= bus.rd_data[7:0];
            if (r_ridx == RD_IDX_W'(NUM_RD - 1)) begin
              r_state <= VLD;
            end else begin
              r_ridx  <= r_ridx + RD_IDX_W'(1);
              r_state <= RD;
            end
          end
        end

        VLD: begin
          // yaw and ay update together so the consumer never sees a mixed sample.
          r_yaw   <= {r_byte[1], r_byte[0]};
`ifdef IMU_ACCEL_EN
          r_ay    <= {r_byte[3], r_byte[2]};
`endif
          r_vld   <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_state <= PWR;
        end
      endcase
    end
  end

  assign bus.wrt      = r_wrt;
  assign bus.cmd      = r_cmd;
  assign bus.yaw_rt   = r_yaw;
  assign bus.vld      = r_vld;
  assign bus.cfg_done = r_cfg_done;
`ifdef IMU_ACCEL_EN
  assign bus.ay       = r_ay;
`else
  assign bus.ay       = 16'h0000;
`endif

endmodule

// File: tb/tb_imu_seq.sv
// tb_imu_seq: directed bench for imu_seq with an SPI monarch responder stub.
// Latency: n/a.
// Backpressure: n/a.
module tb_imu_seq;

  localparam logic [15:0] PWR = 16'd16;

`ifdef IMU_ACCEL_EN
  localparam int NRD = 4;
  localparam bit ACC = 1'b1;
`else
  localparam int NRD = 2;
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imu_seq_if bus();

  imu_seq #(.PWR_WAIT(PWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- SPI responder stub ----------------
  logic [7:0] stub_yl, stub_yh, stub_al, stub_ah;
  int stub_cnt;

  function automatic logic [7:0] stub_byte(input logic [6:0] addr);
    case (addr)
      7'h26:   return stub_yl;
      7'h27:   return stub_yh;
      7'h2A:   return stub_al;
      7'h2B:   return stub_ah;
      default: return 8'h00;
    endcase
  endfunction

  // done comes 4 clocks after wrt is seen; upper rd_data byte is junk on purpose.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt    <= 0;
      bus.done    <= 1'b0;
      bus.rd_data <= 16'h0000;
    end else begin
      bus.done <= 1'b0;
      if (bus.wrt) begin
        stub_cnt <= 3;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          bus.done    <= 1'b1;
          bus.rd_data <= {8'hA5, stub_byte(bus.cmd[14:8])};
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int last_done = 0;
  int vld_gap = -1;
  int wrt_gap = -1;
  int vld_cnt = 0;
  logic [15:0] cmd_log[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) last_done = cyc;
      if (bus.wrt) begin
        cmd_log.push_back(bus.cmd);
        wrt_gap = cyc - last_done;
      end
      if (bus.vld) begin
        vld_cnt++;
        vld_gap = cyc - last_done;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- tables ----------------
  localparam logic [15:0] CFG_EXP [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [15:0] RD_EXP  [4] = '{16'hA600, 16'hA700, 16'hAA00, 16'hAB00};

  typedef struct {
    logic [7:0]  yl, yh, al, ah;
    logic [15:0] exp_yaw;
    logic [15:0] exp_ay;
  } vec_t;

  vec_t vecs [3];

  // Releases reset, checks the power-up silence, the config list and cfg_done.
  // INT is pulsed while configuration is in progress; it must not start a read.
  task automatic do_config(input string tag);
    int got;
    cmd_log.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    check({tag, "_pwr_quiet"}, cmd_log.size(), 0);
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cmd_log.size() >= 1) begin got = 1; break; end
    end
    check({tag, "_first_wrt_timeout"}, got, 1);
    bus.INT = 1'b1;
    repeat (3) @(negedge clk);
    bus.INT = 1'b0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.cfg_done) begin got = 1; break; end
    end
    check({tag, "_cfg_done_timeout"}, got, 1);
    check({tag, "_cfg_count"}, cmd_log.size(), 4);
    for (int i = 0; i < 4 && i < cmd_log.size(); i++) begin
      check($sformatf("%s_cfg_cmd%0d", tag, i), cmd_log[i], CFG_EXP[i]);
    end
    repeat (40) @(negedge clk);
    check({tag, "_no_read_after_cfg"}, cmd_log.size(), 4);
  endtask

  initial begin
    int got;
    int lat;
    int base;
    logic [15:0] yaw_hold;

    vecs[0] = '{8'h34, 8'h12, 8'hF0, 8'hFF, 16'h1234, 16'hFFF0};
    vecs[1] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 16'h8000, 16'h7FFF};
    vecs[2] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 16'hFFFF, 16'h0001};

    bus.INT = 1'b0;
    stub_yl = 8'h00; stub_yh = 8'h00; stub_al = 8'h00; stub_ah = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_wrt", bus.wrt, 0);
    check("rst_vld", bus.vld, 0);
    check("rst_cfg_done", bus.cfg_done, 0);
    check("rst_cmd", bus.cmd, 16'h0000);
    check("rst_yaw", bus.yaw_rt, 16'h0000);
    check("rst_ay", bus.ay, 16'h0000);

    do_config("cfg1");

    // ---- table-driven read bursts ----
    for (int v = 0; v < 3; v++) begin
      stub_yl = vecs[v].yl; stub_yh = vecs[v].yh;
      stub_al = vecs[v].al; stub_ah = vecs[v].ah;
      cmd_log.delete();
      base = vld_cnt;
      @(negedge clk);
      bus.INT = 1'b1;
      lat = 0;
      got = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        lat++;
        if (bus.wrt) begin got = 1; break; end
      end
      check($sformatf("v%0d_wrt_timeout", v), got, 1);
      if (v == 0) check("int_to_wrt_latency", lat, 4);
      @(negedge clk);
      bus.INT = 1'b0;
      got = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (bus.vld) begin got = 1; break; end
      end
      check($sformatf("v%0d_vld_timeout", v), got, 1);
      check($sformatf("v%0d_yaw", v), bus.yaw_rt, vecs[v].exp_yaw);
      check($sformatf("v%0d_ay", v), bus.ay, ACC ? vecs[v].exp_ay : 16'h0000);
      @(negedge clk);
      check($sformatf("v%0d_vld_one_cycle", v), bus.vld, 0);
      if (v == 0) begin
        check("done_to_vld_gap", vld_gap, 2);
        check("done_to_next_wrt_gap", wrt_gap, 2);
      end
      yaw_hold = bus.yaw_rt;
      repeat (5) @(negedge clk);
      check($sformatf("v%0d_yaw_hold", v), bus.yaw_rt, vecs[v].exp_yaw);
      check($sformatf("v%0d_vld_count", v), vld_cnt - base, 1);
      check($sformatf("v%0d_rd_count", v), cmd_log.size(), NRD);
      for (int i = 0; i < NRD && i < cmd_log.size(); i++) begin
        check($sformatf("v%0d_rd_cmd%0d", v, i), cmd_log[i], RD_EXP[i]);
      end
      if (yaw_hold !== bus.yaw_rt) check("yaw_changed_between_vld", bus.yaw_rt, yaw_hold);
    end

    // ---- two extra INT edges during one burst: exactly one more burst ----
    base = vld_cnt;
    @(negedge clk);
    bus.INT = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wrt) begin got = 1; break; end
    end
    check("dbl_wrt_timeout", got, 1);
    bus.INT = 1'b0;
    @(negedge clk); bus.INT = 1'b1;
    repeat (2) @(negedge clk); bus.INT = 1'b0;
    repeat (2) @(negedge clk); bus.INT = 1'b1;
    repeat (2) @(negedge clk); bus.INT = 1'b0;
    repeat (80) @(negedge clk);
    check("dbl_int_vld_count", vld_cnt - base, 2);
    check("dbl_int_yaw", bus.yaw_rt, vecs[2].exp_yaw);

    // ---- reset in the middle of RD_WAIT ----
    @(negedge clk);
    bus.INT = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.wrt) begin got = 1; break; end
    end
    check("mid_rst_wrt_timeout", got, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wrt", bus.wrt, 0);
    check("mid_rst_vld", bus.vld, 0);
    check("mid_rst_cfg_done", bus.cfg_done, 0);
    check("mid_rst_yaw", bus.yaw_rt, 16'h0000);
    bus.INT = 1'b0;
    repeat (2) @(negedge clk);
    do_config("cfg2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
